seq_divider: RTL and testbench

- Sequential n-bit unsigned restoring divider: the inverse companion to the shift-add multiplier.
- Contains its own control FSM and datapath (remainder, quotient and divisor registers, subtractor, down-counter).
- Produces one quotient bit per clock.
- Uses the same level-held start / ready handshake as the multiplier sequencer, so the top level can drive both with one controller.

---
 rtl/seq_divider.sv | 99 +++++++++
 tb/tb_seq_divider.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Shares the level-held start / ready handshake of the shift-add multiplier.
module seq_divider #(
  parameter int N = 8
) (
  input  logic         clock,
  input  logic         nreset,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         ready,
  output logic         div_by_zero
);

  // state    | meaning
  // S_IDLE   | waiting for start; loads operands on the first start edge
  // S_DIV    | one restoring step per edge, count runs N-1 down to 0
  // S_DONE   | result valid, held until start drops
  // 2'b11    | unused, behaves as S_IDLE
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_DIV  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  state_t          state;
  logic [N:0]      r;
  logic [N-1:0]    q;
  logic [N-1:0]    d;
  logic [CW-1:0]   count;

  logic [N+1:0]    t;
  logic            neg;
  logic [N:0]      r_nxt;
  logic [N-1:0]    q_nxt;

  // R < D after every step keeps the shifted partial remainder below 2^(N+1),
  // so the top bit of the widened difference is a clean sign bit.
  always_comb begin
    t     = {r, q[N-1]} - {2'b00, d};
    neg   = t[N+1];
    r_nxt = neg ? {r[N-1:0], q[N-1]} : t[N:0];
    q_nxt = {q[N-2:0], ~neg};
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state       <= S_IDLE;
      r           <= '0;
      q           <= '0;
      d           <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (!start) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_DIV: begin
          r     <= r_nxt;
          q     <= q_nxt;
          count <= count - 1'b1;
          if (count == '0) begin
            quotient  <= q_nxt;
            remainder <= r_nxt[N-1:0];
            state     <= S_DONE;
          end
        end
        S_DONE: state <= S_DONE;
        default: begin
          if (divisor == '0) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
            state       <= S_DONE;
          end else begin
            d           <= divisor;
            q           <= dividend;
            r           <= '0;
            count       <= CNT_LAST;
            div_by_zero <= 1'b0;
            state       <= S_DIV;
          end
        end
      endcase
    end
  end

  assign busy  = (state == S_DIV);
  assign ready = (state == S_DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (N=8) with hand-computed quotients/remainders.
module tb_seq_divider;

  localparam int N = 8;

  logic         clock;
  logic         nreset;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         busy;
  logic         ready;
  logic         div_by_zero;

  int errors = 0;
  int checks = 0;

  seq_divider #(.N(N)) dut (
    .clock      (clock),
    .nreset     (nreset),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .ready      (ready),
    .div_by_zero(div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_cycle();
    start = 1'b0;
    tick();
  endtask

  // Raise start with operands and wait (bounded) for ready; start stays high.
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                       output int edges, output int busy_cnt, output int both_cnt);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    edges    = 0;
    busy_cnt = 0;
    both_cnt = 0;
    while (!ready && edges < 20) begin
      tick();
      edges++;
      if (busy) busy_cnt++;
      if (busy && ready) both_cnt++;
    end
  endtask

  task automatic test_reset();
    nreset   = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready); end
    checks++; if (quotient !== 8'd0) begin errors++; $display("FAIL reset_quotient got=%0d exp=0", quotient); end
    checks++; if (remainder !== 8'd0) begin errors++; $display("FAIL reset_remainder got=%0d exp=0", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
    nreset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int e, b, bb;
    do_op(8'd100, 8'd7, e, b, bb);
    checks++; if (e != 9) begin errors++; $display("FAIL basic_latency got=%0d exp=9", e); end
    checks++; if (b != 8) begin errors++; $display("FAIL basic_busy_cycles got=%0d exp=8", b); end
    checks++; if (bb != 0) begin errors++; $display("FAIL basic_busy_and_ready got=%0d exp=0", bb); end
    checks++; if (quotient !== 8'd14) begin errors++; $display("FAIL basic_quotient got=%0d exp=14", quotient); end
    checks++; if (remainder !== 8'd2) begin errors++; $display("FAIL basic_remainder got=%0d exp=2", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL basic_dbz got=%b exp=0", div_by_zero); end
    idle_cycle();
  endtask

  task automatic test_extremes();
    int e, b, bb;
    do_op(8'd255, 8'd1, e, b, bb);
    checks++; if (e != 9) begin errors++; $display("FAIL max_latency got=%0d exp=9", e); end
    checks++; if (quotient !== 8'd255) begin errors++; $display("FAIL max_quotient got=%0d exp=255", quotient); end
    checks++; if (remainder !== 8'd0) begin errors++; $display("FAIL max_remainder got=%0d exp=0", remainder); end
    idle_cycle();
    do_op(8'd3, 8'd10, e, b, bb);
    checks++; if (e != 9) begin errors++; $display("FAIL small_latency got=%0d exp=9", e); end
    checks++; if (quotient !== 8'd0) begin errors++; $display("FAIL small_quotient got=%0d exp=0", quotient); end
    checks++; if (remainder !== 8'd3) begin errors++; $display("FAIL small_remainder got=%0d exp=3", remainder); end
    idle_cycle();
  endtask

  task automatic test_div_zero();
    int e, b, bb;
    do_op(8'd5, 8'd0, e, b, bb);
    checks++; if (e != 1) begin errors++; $display("FAIL dz_latency got=%0d exp=1", e); end
    checks++; if (b != 0) begin errors++; $display("FAIL dz_busy_cycles got=%0d exp=0", b); end
    checks++; if (quotient !== 8'd255) begin errors++; $display("FAIL dz_quotient got=%0d exp=255", quotient); end
    checks++; if (remainder !== 8'd5) begin errors++; $display("FAIL dz_remainder got=%0d exp=5", remainder); end
    checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_flag got=%b exp=1", div_by_zero); end
    idle_cycle();
    do_op(8'd9, 8'd3, e, b, bb);
    checks++; if (e != 9) begin errors++; $display("FAIL after_dz_latency got=%0d exp=9", e); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL after_dz_flag got=%b exp=0", div_by_zero); end
    checks++; if (quotient !== 8'd3) begin errors++; $display("FAIL after_dz_quotient got=%0d exp=3", quotient); end
    checks++; if (remainder !== 8'd0) begin errors++; $display("FAIL after_dz_remainder got=%0d exp=0", remainder); end
    idle_cycle();
  endtask

  // Previous result is 9/3 = 3 r 0; an aborted 200/9 must not disturb it.
  task automatic test_abort();
    int e, b, bb, rdy_seen;
    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 8'd9;
    rdy_seen = 0;
    repeat (5) begin
      tick();
      if (ready) rdy_seen++;
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before got=%b exp=1", busy); end
    start = 1'b0;
    tick();
    if (ready) rdy_seen++;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy_after got=%b exp=0", busy); end
    checks++; if (rdy_seen != 0) begin errors++; $display("FAIL abort_ready_seen got=%0d exp=0", rdy_seen); end
    checks++; if (quotient !== 8'd3) begin errors++; $display("FAIL abort_quotient_kept got=%0d exp=3", quotient); end
    checks++; if (remainder !== 8'd0) begin errors++; $display("FAIL abort_remainder_kept got=%0d exp=0", remainder); end
    do_op(8'd200, 8'd9, e, b, bb);
    checks++; if (e != 9) begin errors++; $display("FAIL restart_latency got=%0d exp=9", e); end
    checks++; if (quotient !== 8'd22) begin errors++; $display("FAIL restart_quotient got=%0d exp=22", quotient); end
    checks++; if (remainder !== 8'd2) begin errors++; $display("FAIL restart_remainder got=%0d exp=2", remainder); end
  endtask

  // Continues from the 200/9 result with start still high.
  task automatic test_hold();
    int bad_rdy, bad_q, bad_r;
    bad_rdy = 0;
    bad_q   = 0;
    bad_r   = 0;
    for (int i = 0; i < 20; i++) begin
      dividend = 8'(i * 13 + 1);
      divisor  = 8'(i + 1);
      tick();
      if (ready !== 1'b1 || busy !== 1'b0) bad_rdy++;
      if (quotient !== 8'd22) bad_q++;
      if (remainder !== 8'd2) bad_r++;
    end
    checks++; if (bad_rdy != 0) begin errors++; $display("FAIL hold_ready bad_cycles=%0d exp=0", bad_rdy); end
    checks++; if (bad_q != 0) begin errors++; $display("FAIL hold_quotient bad_cycles=%0d exp=0", bad_q); end
    checks++; if (bad_r != 0) begin errors++; $display("FAIL hold_remainder bad_cycles=%0d exp=0", bad_r); end
    start = 1'b0;
    tick();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL hold_drop_ready got=%b exp=0", ready); end
    checks++; if (quotient !== 8'd22) begin errors++; $display("FAIL hold_drop_quotient got=%0d exp=22", quotient); end
  endtask

  task automatic test_reset_mid();
    int e, b, bb;
    start    = 1'b1;
    dividend = 8'd100;
    divisor  = 8'd7;
    repeat (3) tick();
    #2;
    nreset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got=%b exp=0", busy); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL mid_reset_ready got=%b exp=0", ready); end
    checks++; if (quotient !== 8'd0) begin errors++; $display("FAIL mid_reset_quotient got=%0d exp=0", quotient); end
    checks++; if (remainder !== 8'd0) begin errors++; $display("FAIL mid_reset_remainder got=%0d exp=0", remainder); end
    start = 1'b0;
    #1;
    nreset = 1'b1;
    tick();
    do_op(8'd250, 8'd16, e, b, bb);
    checks++; if (e != 9) begin errors++; $display("FAIL post_reset_latency got=%0d exp=9", e); end
    checks++; if (quotient !== 8'd15) begin errors++; $display("FAIL post_reset_quotient got=%0d exp=15", quotient); end
    checks++; if (remainder !== 8'd10) begin errors++; $display("FAIL post_reset_remainder got=%0d exp=10", remainder); end
    idle_cycle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_div_zero();
    test_abort();
    test_hold();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
